stream_arbiter: RTL and testbench

Round-robin N-to-1 arbiter that shares a single valid/ready stream sink among `NUM_S` requesters. It is the fan-in counterpart of the broadcast splitter in the stream fabric and sits in front of any shared downstream consumer. Grants are packet-locked: once a requester wins, it owns the output until its `last` beat is accepted. The grant register, state machine and round-robin pointer are the only state; the data path is a zero-latency mux.

---
 rtl/stream_arbiter.sv | 109 ++++++++++
 tb/tb_stream_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_arbiter.sv
// Round-robin N-to-1 valid/ready arbiter with packet-locked grants.
// The owner keeps the output until its last beat is accepted; the data path is a pure mux.
module stream_arbiter #(
    parameter int NUM_S      = 2,
    parameter int DATA_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [NUM_S-1:0]            s_valid,
    output logic [NUM_S-1:0]            s_ready,
    input  logic [NUM_S*DATA_WIDTH-1:0] s_data,
    input  logic [NUM_S-1:0]            s_last,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [DATA_WIDTH-1:0]       m_data,
    output logic                        m_last,
    output logic [NUM_S-1:0]            m_grant,
    output logic                        busy
);

    localparam int PTR_W = (NUM_S > 1) ? $clog2(NUM_S) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state, state_n;
    logic [NUM_S-1:0]   grant, grant_n;
    logic [PTR_W-1:0]   rr_ptr, rr_ptr_n;
    logic [PTR_W-1:0]   pick_hi, pick_lo, pick, owner, owner_next;
    logic               hit_hi;
    logic               accept_last;

    // Lowest valid index at or above rr_ptr wins; otherwise wrap to the lowest valid index.
    // Descending scan so the lowest matching index is the last one written.
    always_comb begin
        pick_hi = '0;
        pick_lo = '0;
        hit_hi  = 1'b0;
        for (int i = NUM_S - 1; i >= 0; i--) begin
            if (s_valid[i]) begin
                pick_lo = PTR_W'(i);
                if (PTR_W'(i) >= rr_ptr) begin
                    pick_hi = PTR_W'(i);
                    hit_hi  = 1'b1;
                end
            end
        end
        pick = hit_hi ? pick_hi : pick_lo;
    end

    always_comb begin
        owner = '0;
        for (int i = 0; i < NUM_S; i++) begin
            if (grant[i]) owner = PTR_W'(i);
        end
        owner_next = (owner == PTR_W'(NUM_S - 1)) ? '0 : owner + PTR_W'(1);
    end

    // grant is all-zero outside BUSY, so the OR-mux yields zeros when idle
    always_comb begin
        m_data = '0;
        for (int i = 0; i < NUM_S; i++) begin
            if (grant[i]) m_data = m_data | s_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign busy        = (state == BUSY);
    assign m_grant     = grant;
    assign m_last      = |(grant & s_last);
    assign m_valid     = resetn & busy & (|(grant & s_valid));
    assign s_ready     = (resetn & busy) ? (grant & {NUM_S{m_ready}}) : '0;
    assign accept_last = m_valid & m_ready & m_last;

    always_comb begin
        state_n  = state;
        grant_n  = grant;
        rr_ptr_n = rr_ptr;
        case (state)
            IDLE: begin
                if (|s_valid) begin
                    state_n = BUSY;
                    grant_n = NUM_S'(1) << pick;
                end
            end
            BUSY: begin
                if (accept_last) begin
                    state_n  = IDLE;
                    grant_n  = '0;
                    rr_ptr_n = owner_next;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_n;
            grant  <= grant_n;
            rr_ptr <= rr_ptr_n;
        end
    end

endmodule

// File: tb/tb_stream_arbiter.sv
// Scoreboard bench for stream_arbiter (NUM_S=3, DATA_WIDTH=8): expected beats are queued
// as stimulus is driven and compared whenever a handshake appears on the output.
module tb_stream_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic [2:0]  s_valid;
    logic [2:0]  s_ready;
    logic [23:0] s_data;
    logic [2:0]  s_last;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        m_last;
    logic [2:0]  m_grant;
    logic        busy;

    int n_chk   = 0;
    int n_pass  = 0;
    int n_beats = 0;
    logic [11:0] sb[$];

    always #5 clk = ~clk;

    stream_arbiter #(.NUM_S(3), .DATA_WIDTH(8)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .m_grant (m_grant),
        .busy    (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // output monitor: every handshake must match the head of the scoreboard
    initial begin
        logic [11:0] exp;
        forever begin
            @(negedge clk);
            if (m_valid && m_ready) begin
                n_beats++;
                if (sb.size() == 0) begin
                    chk("beat_unexpected", {20'd0, m_grant, m_last, m_data}, 32'hFFFF_FFFF);
                end else begin
                    exp = sb.pop_front();
                    chk("beat", {20'd0, m_grant, m_last, m_data}, {20'd0, exp});
                end
            end
            chk("inv_sready", {29'd0, s_ready}, resetn ? {29'd0, m_grant & {3{m_ready}}} : 32'd0);
            chk("inv_onehot", ($countones(m_grant) <= 1) ? 32'd1 : 32'd0, 32'd1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] rr_g[4];
        logic [7:0] rr_d[4];
        logic [3:0] pat[5];
        int b, n0;
        rr_g = '{3'b001, 3'b010, 3'b100, 3'b001};
        rr_d = '{8'h00, 8'h11, 8'h22, 8'h00};
        pat  = '{4'd1, 4'd0, 4'd1, 4'd0, 4'd1};

        // reset with all requesters valid
        resetn  = 1'b0;
        s_valid = 3'b111;
        s_last  = 3'b111;
        s_data  = {8'h22, 8'h11, 8'h00};
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
            chk("rst_s_ready", {29'd0, s_ready}, 32'd0);
            chk("rst_m_grant", {29'd0, m_grant}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
        end
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_first_grant", {29'd0, m_grant}, 32'b001);

        // round-robin fairness, single-beat packets
        for (int i = 0; i < 4; i++) sb.push_back({rr_g[i], 1'b1, rr_d[i]});
        cyc();
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_grant", {29'd0, m_grant}, {29'd0, rr_g[i]});
            chk("rr_data", {24'd0, m_data}, {24'd0, rr_d[i]});
            cyc();
            if (i == 3) s_valid = 3'b000;
            @(negedge clk);
            chk("rr_idle", {29'd0, m_grant}, 32'd0);
            if (i < 3) cyc();
        end

        // packet lock: s0 sends 4 beats while s1 waits
        cyc();
        s_valid       = 3'b001;
        s_data[7:0]   = 8'h10;
        s_last        = 3'b010;
        for (int k = 0; k < 4; k++) sb.push_back({3'b001, (k == 3), 8'(8'h10 + k)});
        sb.push_back({3'b010, 1'b1, 8'h55});
        cyc();
        s_valid       = 3'b011;
        s_data[15:8]  = 8'h55;
        for (int k = 0; k < 4; k++) begin
            s_data[7:0] = 8'(8'h10 + k);
            s_last[0]   = (k == 3);
            @(negedge clk);
            chk("lock_s_ready1", {31'd0, s_ready[1]}, 32'd0);
            chk("lock_data", {24'd0, m_data}, 32'(8'h10 + k));
            chk("lock_grant", {29'd0, m_grant}, 32'b001);
            cyc();
        end
        s_valid = 3'b010;
        @(negedge clk);
        chk("lock_gap", {29'd0, m_grant}, 32'd0);
        cyc();
        @(negedge clk);
        chk("lock_next_grant", {29'd0, m_grant}, 32'b010);
        cyc();
        s_valid = 3'b000;

        // backpressure on a 3-beat packet from s1
        s_valid      = 3'b010;
        s_data[15:8] = 8'hA0;
        s_last       = 3'b000;
        for (int k = 0; k < 3; k++) sb.push_back({3'b010, (k == 2), 8'(8'hA0 + k)});
        cyc();
        n0 = n_beats;
        b  = 0;
        for (int j = 0; j < 5; j++) begin
            m_ready      = pat[j][0];
            s_data[15:8] = 8'(8'hA0 + b);
            s_last[1]    = (b == 2);
            @(negedge clk);
            chk("bp_s_ready1", {31'd0, s_ready[1]}, {31'd0, pat[j][0]});
            chk("bp_grant", {29'd0, m_grant}, 32'b010);
            chk("bp_data", {24'd0, m_data}, 32'(8'hA0 + b));
            if (pat[j][0]) b++;
            cyc();
        end
        s_valid = 3'b000;
        @(negedge clk);
        chk("bp_release", {29'd0, m_grant}, 32'd0);
        chk("bp_beat_count", 32'(n_beats - n0), 32'd3);

        // pointer skip and wrap from reset
        resetn  = 1'b0;
        s_valid = 3'b000;
        cyc();
        cyc();
        resetn        = 1'b1;
        s_valid       = 3'b100;
        s_data[23:16] = 8'h77;
        s_last        = 3'b100;
        sb.push_back({3'b100, 1'b1, 8'h77});
        @(negedge clk);
        chk("wrap_pre_grant", {29'd0, m_grant}, 32'd0);
        cyc();
        @(negedge clk);
        chk("wrap_first_grant", {29'd0, m_grant}, 32'b100);
        cyc();
        s_valid      = 3'b011;
        s_last       = 3'b011;
        s_data[7:0]  = 8'h30;
        s_data[15:8] = 8'h31;
        sb.push_back({3'b001, 1'b1, 8'h30});
        cyc();
        @(negedge clk);
        chk("wrap_second_grant", {29'd0, m_grant}, 32'b001);
        cyc();
        s_valid = 3'b000;

        // reset during beat 2 of a 4-beat packet
        s_valid     = 3'b001;
        s_data[7:0] = 8'h40;
        s_last      = 3'b000;
        sb.push_back({3'b001, 1'b0, 8'h40});
        cyc();
        @(negedge clk);
        chk("mid_beat1_data", {24'd0, m_data}, 32'h40);
        cyc();
        s_data[7:0] = 8'h41;
        resetn      = 1'b0;
        @(negedge clk);
        chk("mid_rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("mid_rst_s_ready", {29'd0, s_ready}, 32'd0);
        cyc();
        @(negedge clk);
        chk("mid_after_grant", {29'd0, m_grant}, 32'd0);
        chk("mid_after_m_valid", {31'd0, m_valid}, 32'd0);
        resetn        = 1'b1;
        s_valid       = 3'b110;
        s_last        = 3'b110;
        s_data[15:8]  = 8'h61;
        s_data[23:16] = 8'h62;
        sb.push_back({3'b010, 1'b1, 8'h61});
        @(negedge clk);
        chk("mid_regrant", {29'd0, m_grant}, 32'b010);
        cyc();
        s_valid = 3'b000;
        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
